// File: rtl/latency_io_sched_if.sv
// Handshake, launch and status bundle for the latency I/O sequencing controller.
// master = the side that configures and launches, slave = the controller itself.
interface latency_io_sched_if #(
  parameter int NUM_PORTS      = 4,
  parameter int MAX_PIPE_STAGE = 16,
  parameter int CNT_W          = 16
);
  localparam int LW = $clog2(MAX_PIPE_STAGE);
  localparam int PW = $clog2(NUM_PORTS);

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [PW-1:0]           cfg_port;
  logic                    cfg_dir;
  logic [LW-1:0]           cfg_lat;
  logic                    start;
  logic [CNT_W-1:0]        num_iter;
  logic [LW-1:0]           fabric_lat;
  logic                    stall;
  logic [NUM_PORTS*LW-1:0] latency_in;
  logic [NUM_PORTS*LW-1:0] latency_out;
  logic                    pipe_clr;
  logic                    issue;
  logic [CNT_W-1:0]        issue_idx;
  logic                    wb_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output cfg_valid, cfg_port, cfg_dir, cfg_lat, start, num_iter, fabric_lat, stall,
    input  cfg_ready, latency_in, latency_out, pipe_clr, issue, issue_idx,
           wb_valid, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_port, cfg_dir, cfg_lat, start, num_iter, fabric_lat, stall,
    output cfg_ready, latency_in, latency_out, pipe_clr, issue, issue_idx,
           wb_valid, busy, done
  );
endinterface

// File: rtl/latency_io_sched.sv
// Latency I/O sequencing controller: holds shadow/active per-port latencies,
// clears the latency pipes on launch, issues one RF read per cycle and
// tracks in-flight iterations until the pipeline has drained.
module latency_io_sched #(
  parameter int NUM_PORTS      = 4,
  parameter int MAX_PIPE_STAGE = 16,
  parameter int CNT_W          = 16
) (
  input logic              clk,
  input logic              rst,
  latency_io_sched_if.slave bus
);
  localparam int LW   = $clog2(MAX_PIPE_STAGE);
  localparam int PW   = $clog2(NUM_PORTS);
  localparam int LL_W = LW + 2;
  localparam int SR_D = 3 * (MAX_PIPE_STAGE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [LW-1:0]    shadow_in_reg  [NUM_PORTS];
  logic [LW-1:0]    shadow_out_reg [NUM_PORTS];
  logic [LW-1:0]    active_in_reg  [NUM_PORTS];
  logic [LW-1:0]    active_out_reg [NUM_PORTS];
  logic [CNT_W-1:0] num_iter_reg;
  logic [CNT_W-1:0] issue_idx_reg;
  logic [LW-1:0]    fabric_lat_reg;
  logic [LL_W-1:0]  total_lat_reg, total_lat_next, total_lat_m1;
  logic [SR_D-1:0]  wb_sr_reg;
  logic [CNT_W:0]   outstanding_reg;
  logic [LW-1:0]    max_in, max_out;
  logic             cfg_fire, start_fire, issue_int, wb_int, done_int, last_issue;

  assign cfg_fire   = (state_reg == ST_IDLE) && bus.cfg_valid;
  assign start_fire = (state_reg == ST_IDLE) && bus.start;
  assign issue_int  = (state_reg == ST_RUN) && !bus.stall;
  assign done_int   = (state_reg == ST_DRAIN) && (outstanding_reg == '0);
  assign last_issue = issue_int && (issue_idx_reg == num_iter_reg - CNT_W'(1));

  // Per-port shadow (config-written) and active (launch-applied) latency registers
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_in_reg[gi]  <= '0;
          shadow_out_reg[gi] <= '0;
          active_in_reg[gi]  <= '0;
          active_out_reg[gi] <= '0;
        end else begin
          if (cfg_fire && bus.cfg_port == PW'(gi)) begin
            if (bus.cfg_dir) shadow_out_reg[gi] <= bus.cfg_lat;
            else             shadow_in_reg[gi]  <= bus.cfg_lat;
          end
          if (state_reg == ST_CLEAR) begin
            active_in_reg[gi]  <= shadow_in_reg[gi];
            active_out_reg[gi] <= shadow_out_reg[gi];
          end
        end
      end
      assign bus.latency_in[gi*LW +: LW]  = active_in_reg[gi];
      assign bus.latency_out[gi*LW +: LW] = active_out_reg[gi];
    end
  endgenerate

  // End-to-end latency of the config being applied: worst input pipe + fabric + worst output pipe
  always_comb begin
    max_in  = '0;
    max_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (shadow_in_reg[i] > max_in)   max_in  = shadow_in_reg[i];
      if (shadow_out_reg[i] > max_out) max_out = shadow_out_reg[i];
    end
    total_lat_next = LL_W'(max_in) + LL_W'(fabric_lat_reg) + LL_W'(max_out);
  end

  // Write-back flag is the issue strobe delayed by L; L=0 passes issue straight through
  always_comb begin
    total_lat_m1 = total_lat_reg - LL_W'(1);
    wb_int = 1'b0;
    if (total_lat_reg == '0)                 wb_int = issue_int;
    else if (total_lat_reg <= LL_W'(SR_D))   wb_int = wb_sr_reg[total_lat_m1];
  end

  // FSM next-state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_fire) state_next = ST_CLEAR;
      ST_CLEAR: state_next = (num_iter_reg != '0) ? ST_RUN : ST_DRAIN;
      ST_RUN:   if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: if (done_int) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, launch parameters, issue index, tracker and in-flight counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      num_iter_reg    <= '0;
      fabric_lat_reg  <= '0;
      total_lat_reg   <= '0;
      issue_idx_reg   <= '0;
      wb_sr_reg       <= '0;
      outstanding_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_fire) begin
        num_iter_reg   <= bus.num_iter;
        fabric_lat_reg <= bus.fabric_lat;
      end
      if (state_reg == ST_CLEAR) begin
        total_lat_reg   <= total_lat_next;
        issue_idx_reg   <= '0;
        wb_sr_reg       <= '0;
        outstanding_reg <= '0;
      end else begin
        if (issue_int) issue_idx_reg <= issue_idx_reg + CNT_W'(1);
        wb_sr_reg <= {wb_sr_reg[SR_D-2:0], issue_int};
        if (issue_int && !wb_int)
          outstanding_reg <= outstanding_reg + (CNT_W+1)'(1);
        else if (!issue_int && wb_int && outstanding_reg != '0)
          outstanding_reg <= outstanding_reg - (CNT_W+1)'(1);
      end
    end
  end

  assign bus.cfg_ready = (state_reg == ST_IDLE);
  assign bus.pipe_clr  = (state_reg == ST_CLEAR);
  assign bus.issue     = issue_int;
  assign bus.issue_idx = issue_idx_reg;
  assign bus.wb_valid  = wb_int;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = done_int;
endmodule

// File: tb/tb_latency_io_sched.sv
// Directed bench for latency_io_sched: reset, basic launch, stall, zero
// iterations, config/start lockout during RUN, and reset abort.
module tb_latency_io_sched;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  latency_io_sched_if #(.NUM_PORTS(4), .MAX_PIPE_STAGE(16), .CNT_W(16)) bus ();

  latency_io_sched #(.NUM_PORTS(4), .MAX_PIPE_STAGE(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; one-cycle requests fall back to idle values
  task automatic tick();
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] p, input logic d, input logic [3:0] lat);
    tick();
    bus.cfg_valid = 1'b1;
    bus.cfg_port  = p;
    bus.cfg_dir   = d;
    bus.cfg_lat   = lat;
  endtask

  task automatic launch(input logic [3:0] fab, input logic [15:0] n);
    tick();
    bus.start      = 1'b1;
    bus.fabric_lat = fab;
    bus.num_iter   = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    #1;
    total++; if (bus.pipe_clr !== 1'b0) begin bad++; $display("FAIL reset_pipe_clr got=%b exp=0", bus.pipe_clr); end
    total++; if (bus.issue !== 1'b0) begin bad++; $display("FAIL reset_issue got=%b exp=0", bus.issue); end
    total++; if (bus.issue_idx !== 16'd0) begin bad++; $display("FAIL reset_issue_idx got=%0d exp=0", bus.issue_idx); end
    total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", bus.wb_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", bus.cfg_ready); end
    total++; if (bus.latency_in !== 16'h0000) begin bad++; $display("FAIL reset_latency_in got=%h exp=0000", bus.latency_in); end
    total++; if (bus.latency_out !== 16'h0000) begin bad++; $display("FAIL reset_latency_out got=%h exp=0000", bus.latency_out); end
    tick();
    rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  // port2 in=3, port0 out=5, fabric=4 -> L=12; three iterations, no stall
  task automatic test_basic();
    logic [31:0] iss_m, wb_m;
    int idx_exp;
    iss_m = 32'h0000_001C;
    wb_m  = 32'h0001_C000;
    idx_exp = 0;
    cfg_write(2'd2, 1'b0, 4'd3);
    cfg_write(2'd0, 1'b1, 4'd5);
    launch(4'd4, 16'd3);
    for (int k = 1; k <= 20; k++) begin
      tick();
      #1;
      total++; if (bus.pipe_clr !== (k == 1)) begin bad++; $display("FAIL basic_pipe_clr k=%0d got=%b exp=%b", k, bus.pipe_clr, (k == 1)); end
      total++; if (bus.issue !== iss_m[k]) begin bad++; $display("FAIL basic_issue k=%0d got=%b exp=%b", k, bus.issue, iss_m[k]); end
      if (iss_m[k]) begin
        total++; if (bus.issue_idx !== 16'(idx_exp)) begin bad++; $display("FAIL basic_issue_idx k=%0d got=%0d exp=%0d", k, bus.issue_idx, idx_exp); end
        idx_exp++;
      end
      total++; if (bus.wb_valid !== wb_m[k]) begin bad++; $display("FAIL basic_wb_valid k=%0d got=%b exp=%b", k, bus.wb_valid, wb_m[k]); end
      total++; if (bus.done !== (k == 17)) begin bad++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, bus.done, (k == 17)); end
      total++; if (bus.busy !== (k <= 17)) begin bad++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, bus.busy, (k <= 17)); end
      if (k == 2) begin
        total++; if (bus.latency_in !== 16'h0300) begin bad++; $display("FAIL basic_latency_in got=%h exp=0300", bus.latency_in); end
        total++; if (bus.latency_out !== 16'h0005) begin bad++; $display("FAIL basic_latency_out got=%h exp=0005", bus.latency_out); end
      end
    end
    $display("basic launch: 3 iterations, L=12 checked");
  endtask

  // same config, stall high at t+3
  task automatic test_stall();
    logic [31:0] iss_m, wb_m;
    int idx_exp;
    iss_m = 32'h0000_0034;
    wb_m  = 32'h0003_4000;
    idx_exp = 0;
    launch(4'd4, 16'd3);
    for (int k = 1; k <= 21; k++) begin
      tick();
      bus.stall = (k == 3);
      #1;
      total++; if (bus.issue !== iss_m[k]) begin bad++; $display("FAIL stall_issue k=%0d got=%b exp=%b", k, bus.issue, iss_m[k]); end
      if (iss_m[k]) begin
        total++; if (bus.issue_idx !== 16'(idx_exp)) begin bad++; $display("FAIL stall_issue_idx k=%0d got=%0d exp=%0d", k, bus.issue_idx, idx_exp); end
        idx_exp++;
      end
      total++; if (bus.wb_valid !== wb_m[k]) begin bad++; $display("FAIL stall_wb_valid k=%0d got=%b exp=%b", k, bus.wb_valid, wb_m[k]); end
      total++; if (bus.done !== (k == 18)) begin bad++; $display("FAIL stall_done k=%0d got=%b exp=%b", k, bus.done, (k == 18)); end
    end
    bus.stall = 1'b0;
    $display("stall launch: stall at t+3 checked");
  endtask

  task automatic test_zero_iter();
    launch(4'd0, 16'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      #1;
      total++; if (bus.pipe_clr !== (k == 1)) begin bad++; $display("FAIL zero_pipe_clr k=%0d got=%b exp=%b", k, bus.pipe_clr, (k == 1)); end
      total++; if (bus.done !== (k == 2)) begin bad++; $display("FAIL zero_done k=%0d got=%b exp=%b", k, bus.done, (k == 2)); end
      total++; if (bus.issue !== 1'b0) begin bad++; $display("FAIL zero_issue k=%0d got=%b exp=0", k, bus.issue); end
      total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL zero_wb_valid k=%0d got=%b exp=0", k, bus.wb_valid); end
      total++; if (bus.busy !== (k <= 2)) begin bad++; $display("FAIL zero_busy k=%0d got=%b exp=%b", k, bus.busy, (k <= 2)); end
    end
    $display("zero-iteration launch checked");
  endtask

  task automatic test_run_lockout();
    logic [31:0] iss_m, wb_m;
    int n_iss;
    // launch A: L = 3 + 0 + 5 = 8, four iterations; cfg write and start in RUN are dropped
    iss_m = 32'h0000_003C;
    wb_m  = 32'h0000_3C00;
    n_iss = 0;
    launch(4'd0, 16'd4);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 3) begin
        bus.cfg_valid = 1'b1; bus.cfg_port = 2'd2; bus.cfg_dir = 1'b0; bus.cfg_lat = 4'd7;
        bus.start = 1'b1; bus.num_iter = 16'd9;
      end
      #1;
      if (k == 3) begin
        total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL lock_cfg_ready got=%b exp=0", bus.cfg_ready); end
      end
      if (bus.issue) n_iss++;
      total++; if (bus.issue !== iss_m[k]) begin bad++; $display("FAIL lock_issue k=%0d got=%b exp=%b", k, bus.issue, iss_m[k]); end
      total++; if (bus.wb_valid !== wb_m[k]) begin bad++; $display("FAIL lock_wb_valid k=%0d got=%b exp=%b", k, bus.wb_valid, wb_m[k]); end
      total++; if (bus.done !== (k == 14)) begin bad++; $display("FAIL lock_done k=%0d got=%b exp=%b", k, bus.done, (k == 14)); end
      total++; if (bus.busy !== (k <= 14)) begin bad++; $display("FAIL lock_busy k=%0d got=%b exp=%b", k, bus.busy, (k <= 14)); end
    end
    total++; if (n_iss != 4) begin bad++; $display("FAIL lock_issue_count got=%0d exp=4", n_iss); end
    $display("run lockout launch: 4 iterations checked");
    // launch B: config write with start is applied; port2 keeps 3 -> L=8
    tick();
    bus.cfg_valid = 1'b1; bus.cfg_port = 2'd1; bus.cfg_dir = 1'b0; bus.cfg_lat = 4'd2;
    bus.start = 1'b1; bus.num_iter = 16'd1; bus.fabric_lat = 4'd0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      #1;
      if (k == 2) begin
        total++; if (bus.latency_in !== 16'h0320) begin bad++; $display("FAIL cfgstart_latency_in got=%h exp=0320", bus.latency_in); end
      end
      total++; if (bus.issue !== (k == 2)) begin bad++; $display("FAIL cfgstart_issue k=%0d got=%b exp=%b", k, bus.issue, (k == 2)); end
      total++; if (bus.wb_valid !== (k == 10)) begin bad++; $display("FAIL cfgstart_wb_valid k=%0d got=%b exp=%b", k, bus.wb_valid, (k == 10)); end
      total++; if (bus.done !== (k == 11)) begin bad++; $display("FAIL cfgstart_done k=%0d got=%b exp=%b", k, bus.done, (k == 11)); end
    end
    $display("config-with-start launch checked");
  endtask

  // stalled launch aborted by reset at t+6
  task automatic test_reset_abort();
    logic [31:0] iss_m;
    iss_m = 32'h0000_0034;
    launch(4'd4, 16'd3);
    for (int k = 1; k <= 25; k++) begin
      tick();
      bus.stall = (k == 3);
      if (k == 6) rst = 1'b1;
      #1;
      if (k <= 6) begin
        total++; if (bus.issue !== iss_m[k]) begin bad++; $display("FAIL abort_issue k=%0d got=%b exp=%b", k, bus.issue, iss_m[k]); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done_pre k=%0d got=%b exp=0", k, bus.done); end
      end else begin
        if (k == 7) begin
          total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL abort_cfg_ready got=%b exp=1", bus.cfg_ready); end
          total++; if (bus.pipe_clr !== 1'b0) begin bad++; $display("FAIL abort_pipe_clr got=%b exp=0", bus.pipe_clr); end
          total++; if (bus.issue_idx !== 16'd0) begin bad++; $display("FAIL abort_issue_idx got=%0d exp=0", bus.issue_idx); end
          total++; if (bus.latency_in !== 16'h0000) begin bad++; $display("FAIL abort_latency_in got=%h exp=0000", bus.latency_in); end
          total++; if (bus.latency_out !== 16'h0000) begin bad++; $display("FAIL abort_latency_out got=%h exp=0000", bus.latency_out); end
          rst = 1'b0;
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy k=%0d got=%b exp=0", k, bus.busy); end
        total++; if (bus.issue !== 1'b0) begin bad++; $display("FAIL abort_issue_post k=%0d got=%b exp=0", k, bus.issue); end
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL abort_wb_valid k=%0d got=%b exp=0", k, bus.wb_valid); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done_post k=%0d got=%b exp=0", k, bus.done); end
      end
    end
    $display("reset abort at t+6 checked");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_port   = 2'd0;
    bus.cfg_dir    = 1'b0;
    bus.cfg_lat    = 4'd0;
    bus.start      = 1'b0;
    bus.num_iter   = 16'd0;
    bus.fabric_lat = 4'd0;
    bus.stall      = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_iter();
    test_run_lockout();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
